// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, the M-stage
// control bubble and the alignment rule.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_RSVD = 2'b11;  // behaves as a word access

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Control fields of the M register; data fields are simply cleared to zero.
    typedef struct packed {
        logic jump;
        logic reg_write;
        logic misalign;
    } m_ctrl_t;

    localparam m_ctrl_t M_CTRL_BUBBLE = '{jump: 1'b0, reg_write: 1'b0, misalign: 1'b0};

    // Halves need an even address, words (and the reserved size) a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            MEM_BYTE:           r = 1'b0;
            MEM_HALF:           r = lo[0];
            MEM_WORD, MEM_RSVD: r = (lo != 2'b00);
            default:            r = (lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_bytewise.sv
// DEPTH x DATA_W data RAM with one write enable per byte lane.
// Writes are synchronous, reads are combinational; contents are never reset.
module dm_bytewise #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage_mc.sv
// MIPS MEM stage: E->M pipeline register in front of a byte-enabled data RAM,
// with sub-word loads/stores, misalignment trap, flush, and an optional
// fixed number of wait states per memory access.
module memory_stage_mc
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int MTR_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flushM,
    input  logic              jumpE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemReadE,
    input  logic [1:0]        MemSizeE,
    input  logic              MemSignedE,
    input  logic [MTR_W-1:0]  MemtoRegE,
    input  logic [4:0]        WriteRegE,
    input  logic [DATA_W-1:0] ALUMultOutE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [DATA_W-1:0] PCPlus4E,
    output logic              stallM,
    output logic              jumpM,
    output logic              RegWriteM,
    output logic [MTR_W-1:0]  MemtoRegM,
    output logic [4:0]        WriteRegM,
    output logic [DATA_W-1:0] ALUMultOutM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic [DATA_W-1:0] PCPlus8M,
    output logic              misalignM
);

    localparam int AW    = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

    mem_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              mem_op;
    logic              misaligned;
    logic              wait_req;
    logic              capture;
    logic [1:0]        lane;
    logic [AW-1:0]     word_idx;
    logic [NB-1:0]     byte_en;
    logic [NB-1:0]     ram_be;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] load_data;
    m_ctrl_t           ctrl_p0;
    m_ctrl_t           ctrl_p1;
    logic              unused_addr_hi;

    // Shift the addressed lane down is done by the caller; this only extends.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] w,
                                                      input logic [1:0]        size,
                                                      input logic              sgn);
        logic [DATA_W-1:0] r;
        case (size)
            MEM_BYTE: r = {{(DATA_W-8){sgn & w[7]}}, w[7:0]};
            MEM_HALF: r = {{(DATA_W-16){sgn & w[15]}}, w[15:0]};
            default:  r = w;
        endcase
        return r;
    endfunction

    assign mem_op     = MemReadE | MemWriteE;
    assign misaligned = mem_op & is_misaligned(MemSizeE, ALUMultOutE[1:0]);
    assign lane       = ALUMultOutE[1:0];
    assign word_idx   = ALUMultOutE[AW+1:2];
    assign wait_req   = HAS_WAIT && mem_op && !misaligned;

    // Address bits above the RAM index alias back into the array.
    assign unused_addr_hi = ^ALUMultOutE[DATA_W-1:AW+2];

    // Stall is held low while in reset so nothing upstream freezes on a dead stage.
    assign stallM = rst & (((state == ST_IDLE) && wait_req) ||
                           ((state == ST_WAIT) && (cnt != '0)));

    // Next-state logic; flush overrides everything and drops any pending access.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        if (flushM) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wait_req) begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        capture = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        capture    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Access FSM and wait-state counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Store lane steering: replicate the datum and raise the lanes it occupies.
    always_comb begin
        byte_en = '0;
        wr_data = WriteDataE;
        case (MemSizeE)
            MEM_BYTE: begin
                byte_en = NB'(1) << lane;
                for (int i = 0; i < NB; i++) wr_data[8*i +: 8] = WriteDataE[7:0];
            end
            MEM_HALF: begin
                byte_en = NB'(3) << {lane[1], 1'b0};
                for (int i = 0; i < NB; i++) wr_data[8*i +: 8] = WriteDataE[8*(i%2) +: 8];
            end
            MEM_WORD, MEM_RSVD: byte_en = '1;
            default:            byte_en = '1;
        endcase
    end

    // The store commits only on the capture edge, never while reset is asserted.
    assign ram_be = (capture && MemWriteE && !misaligned && rst) ? byte_en : '0;

    dm_bytewise #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .addr  (word_idx),
        .be    (ram_be),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    // Read data is the pre-write word, so a combined read+write returns old contents.
    assign load_data = (MemReadE && !misaligned)
                     ? extend_load(rd_word >> {lane, 3'b000}, MemSizeE, MemSignedE)
                     : '0;

    assign ctrl_p0 = '{jump: jumpE, reg_write: RegWriteE & ~misaligned, misalign: misaligned};

    // ---- E -> M boundary: load on capture, bubble otherwise ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_p1     <= M_CTRL_BUBBLE;
            MemtoRegM   <= '0;
            WriteRegM   <= '0;
            ALUMultOutM <= '0;
            ReadDataM   <= '0;
            PCPlus8M    <= '0;
        end else if (capture) begin
            ctrl_p1     <= ctrl_p0;
            MemtoRegM   <= MemtoRegE;
            WriteRegM   <= WriteRegE;
            ALUMultOutM <= ALUMultOutE;
            ReadDataM   <= load_data;
            PCPlus8M    <= PCPlus4E + DATA_W'(4);
        end else begin
            ctrl_p1     <= M_CTRL_BUBBLE;
            MemtoRegM   <= '0;
            WriteRegM   <= '0;
            ALUMultOutM <= '0;
            ReadDataM   <= '0;
            PCPlus8M    <= '0;
        end
    end

    assign jumpM     = ctrl_p1.jump;
    assign RegWriteM = ctrl_p1.reg_write;
    assign misalignM = ctrl_p1.misalign;

endmodule
